// File: rtl/idu_alu_iq_pkg.sv
// Shared constants and entry layout for the IDU ALU issue queue.
package idu_alu_iq_pkg;

  localparam int IID_W  = 5;
  localparam int PREG_W = 6;
  localparam int XLEN   = 64;

  localparam logic [6:0] R_ALU64 = 7'b0110011;
  localparam logic [6:0] R_ALU32 = 7'b0111011;
  localparam logic [6:0] I_ALU64 = 7'b0010011;
  localparam logic [6:0] I_ALU32 = 7'b0011011;
  localparam logic [6:0] U_AUIPC = 7'b0010111;
  localparam logic [6:0] U_LUI   = 7'b0110111;

  typedef struct packed {
    logic [IID_W-1:0]  iid;
    logic [6:0]        opcode;
    logic [6:0]        funct7;
    logic [2:0]        funct3;
    logic [XLEN-1:0]   pc;
    logic              psrc1_vld;
    logic [PREG_W-1:0] psrc1;
    logic              psrc1_rdy;
    logic [XLEN-1:0]   psrc1_value;
    logic              psrc2_vld;
    logic [PREG_W-1:0] psrc2;
    logic              psrc2_rdy;
    logic [XLEN-1:0]   psrc2_value;
    logic              pdst_vld;
    logic [PREG_W-1:0] pdst;
    logic              imm_vld;
    logic [XLEN-1:0]   imm;
  } iq_entry_t;

endpackage

// File: rtl/idu_alu_iq_if.sv
// Dispatch, writeback-snoop and issue signals of the IDU ALU issue queue.
interface idu_alu_iq_if #(
  parameter int DEPTH = 8
);
  import idu_alu_iq_pkg::*;

  logic              rtu_global_flush;
  logic              disp_vld;
  logic              disp_rdy;
  logic [IID_W-1:0]  disp_iid;
  logic [6:0]        disp_opcode;
  logic [6:0]        disp_funct7;
  logic [2:0]        disp_funct3;
  logic [XLEN-1:0]   disp_pc;
  logic              disp_psrc1_vld;
  logic [PREG_W-1:0] disp_psrc1;
  logic              disp_psrc1_rdy;
  logic [XLEN-1:0]   disp_psrc1_value;
  logic              disp_psrc2_vld;
  logic [PREG_W-1:0] disp_psrc2;
  logic              disp_psrc2_rdy;
  logic [XLEN-1:0]   disp_psrc2_value;
  logic              disp_pdst_vld;
  logic [PREG_W-1:0] disp_pdst;
  logic              disp_imm_vld;
  logic [XLEN-1:0]   disp_imm;

  logic              exu_idu_rf_alu_wb_vld;
  logic [PREG_W-1:0] exu_idu_rf_alu_wb_preg;
  logic [XLEN-1:0]   exu_idu_rf_alu_wb_data;

  logic              idu_exu_alu_vld;
  logic [IID_W-1:0]  idu_exu_alu_iid;
  logic [6:0]        idu_exu_alu_opcode;
  logic [6:0]        idu_exu_alu_funct7;
  logic [2:0]        idu_exu_alu_funct3;
  logic [XLEN-1:0]   idu_exu_alu_pc;
  logic              idu_exu_alu_psrc1_vld;
  logic [XLEN-1:0]   idu_exu_alu_psrc1_value;
  logic              idu_exu_alu_psrc2_vld;
  logic [XLEN-1:0]   idu_exu_alu_psrc2_value;
  logic              idu_exu_alu_pdst_vld;
  logic [PREG_W-1:0] idu_exu_alu_pdst;
  logic              idu_exu_alu_imm_vld;
  logic [XLEN-1:0]   idu_exu_alu_imm;

  logic [$clog2(DEPTH+1)-1:0] iq_count;

  modport master (
    output rtu_global_flush, disp_vld, disp_iid, disp_opcode, disp_funct7, disp_funct3,
           disp_pc, disp_psrc1_vld, disp_psrc1, disp_psrc1_rdy, disp_psrc1_value,
           disp_psrc2_vld, disp_psrc2, disp_psrc2_rdy, disp_psrc2_value,
           disp_pdst_vld, disp_pdst, disp_imm_vld, disp_imm,
           exu_idu_rf_alu_wb_vld, exu_idu_rf_alu_wb_preg, exu_idu_rf_alu_wb_data,
    input  disp_rdy, idu_exu_alu_vld, idu_exu_alu_iid, idu_exu_alu_opcode,
           idu_exu_alu_funct7, idu_exu_alu_funct3, idu_exu_alu_pc,
           idu_exu_alu_psrc1_vld, idu_exu_alu_psrc1_value,
           idu_exu_alu_psrc2_vld, idu_exu_alu_psrc2_value,
           idu_exu_alu_pdst_vld, idu_exu_alu_pdst, idu_exu_alu_imm_vld, idu_exu_alu_imm,
           iq_count
  );

  modport slave (
    input  rtu_global_flush, disp_vld, disp_iid, disp_opcode, disp_funct7, disp_funct3,
           disp_pc, disp_psrc1_vld, disp_psrc1, disp_psrc1_rdy, disp_psrc1_value,
           disp_psrc2_vld, disp_psrc2, disp_psrc2_rdy, disp_psrc2_value,
           disp_pdst_vld, disp_pdst, disp_imm_vld, disp_imm,
           exu_idu_rf_alu_wb_vld, exu_idu_rf_alu_wb_preg, exu_idu_rf_alu_wb_data,
    output disp_rdy, idu_exu_alu_vld, idu_exu_alu_iid, idu_exu_alu_opcode,
           idu_exu_alu_funct7, idu_exu_alu_funct3, idu_exu_alu_pc,
           idu_exu_alu_psrc1_vld, idu_exu_alu_psrc1_value,
           idu_exu_alu_psrc2_vld, idu_exu_alu_psrc2_value,
           idu_exu_alu_pdst_vld, idu_exu_alu_pdst, idu_exu_alu_imm_vld, idu_exu_alu_imm,
           iq_count
  );

endinterface

// File: rtl/idu_alu_iq_entry.sv
// One issue-queue slot: storage, writeback wakeup/capture and ready flag.
module idu_alu_iq_entry
  import idu_alu_iq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_clk,
  input  logic              flush_i,
  input  logic              load_en_i,
  input  logic              load_vld_i,
  input  iq_entry_t         load_data_i,
  input  logic              wb_vld_i,
  input  logic [PREG_W-1:0] wb_preg_i,
  input  logic [XLEN-1:0]   wb_data_i,
  output logic              vld_o,
  output iq_entry_t         data_o,
  output logic              rdy_o
);

  logic      vld_q, vld_d;
  iq_entry_t ent_q, ent_d;

  // Wakeup is applied after the load mux so shifted-in and freshly dispatched
  // contents still catch a writeback seen in the same cycle.
  always_comb begin
    vld_d = load_en_i ? load_vld_i  : vld_q;
    ent_d = load_en_i ? load_data_i : ent_q;
    if (wb_vld_i && vld_d) begin
      if (ent_d.psrc1_vld && !ent_d.psrc1_rdy && (ent_d.psrc1 == wb_preg_i)) begin
        ent_d.psrc1_rdy   = 1'b1;
        ent_d.psrc1_value = wb_data_i;
      end
      if (ent_d.psrc2_vld && !ent_d.psrc2_rdy && (ent_d.psrc2 == wb_preg_i)) begin
        ent_d.psrc2_rdy   = 1'b1;
        ent_d.psrc2_value = wb_data_i;
      end
    end
    if (flush_i) vld_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst_clk) begin
    if (rst_clk) begin
      vld_q <= 1'b0;
      ent_q <= '0;
    end else begin
      vld_q <= vld_d;
      ent_q <= ent_d;
    end
  end

  assign vld_o  = vld_q;
  assign data_o = ent_q;
  assign rdy_o  = vld_q & ent_q.psrc1_rdy & ent_q.psrc2_rdy;

endmodule

// File: rtl/idu_alu_iq.sv
// Collapsing ALU issue queue: oldest-ready select, shift-down on issue, count.
// Optional IDU_ALU_IQ_DEBUG_PRINT_EN adds simulation-only issue/dispatch prints.
module idu_alu_iq
  import idu_alu_iq_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input logic         clk,
  input logic         rst_clk,
  idu_alu_iq_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] wr_idx;
  iq_entry_t     ent [DEPTH+1];
  logic [DEPTH:0] vld;
  logic [DEPTH-1:0] rdy, sel_oh, load_en, load_vld;
  iq_entry_t     load_data [DEPTH];
  iq_entry_t     disp_ent, iss_ent;
  logic          any_rdy, issue, disp_rdy_w, disp_acc, flush;

  assign flush      = bus.rtu_global_flush;
  assign ent[DEPTH] = '0;
  assign vld[DEPTH] = 1'b0;

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    idu_alu_iq_entry u_entry (
      .clk         (clk),
      .rst_clk     (rst_clk),
      .flush_i     (flush),
      .load_en_i   (load_en[g]),
      .load_vld_i  (load_vld[g]),
      .load_data_i (load_data[g]),
      .wb_vld_i    (bus.exu_idu_rf_alu_wb_vld),
      .wb_preg_i   (bus.exu_idu_rf_alu_wb_preg),
      .wb_data_i   (bus.exu_idu_rf_alu_wb_data),
      .vld_o       (vld[g]),
      .data_o      (ent[g]),
      .rdy_o       (rdy[g])
    );
  end

  always_comb begin
    disp_ent             = '0;
    disp_ent.iid         = bus.disp_iid;
    disp_ent.opcode      = bus.disp_opcode;
    disp_ent.funct7      = bus.disp_funct7;
    disp_ent.funct3      = bus.disp_funct3;
    disp_ent.pc          = bus.disp_pc;
    disp_ent.psrc1_vld   = bus.disp_psrc1_vld;
    disp_ent.psrc1       = bus.disp_psrc1;
    disp_ent.psrc1_rdy   = !bus.disp_psrc1_vld || bus.disp_psrc1_rdy;
    disp_ent.psrc1_value = (bus.disp_psrc1_vld && bus.disp_psrc1_rdy) ? bus.disp_psrc1_value : '0;
    disp_ent.psrc2_vld   = bus.disp_psrc2_vld;
    disp_ent.psrc2       = bus.disp_psrc2;
    disp_ent.psrc2_rdy   = !bus.disp_psrc2_vld || bus.disp_psrc2_rdy;
    disp_ent.psrc2_value = (bus.disp_psrc2_vld && bus.disp_psrc2_rdy) ? bus.disp_psrc2_value : '0;
    disp_ent.pdst_vld    = bus.disp_pdst_vld;
    disp_ent.pdst        = bus.disp_pdst;
    disp_ent.imm_vld     = bus.disp_imm_vld;
    disp_ent.imm         = bus.disp_imm;
  end

  always_comb begin
    sel_oh  = '0;
    any_rdy = 1'b0;
    iss_ent = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (rdy[i] && !any_rdy) begin
        sel_oh[i] = 1'b1;
        iss_ent   = ent[i];
        any_rdy   = 1'b1;
      end
    end
    issue = any_rdy && !flush;
    if (flush) iss_ent = '0;
  end

  assign disp_rdy_w = (count_q < CW'(DEPTH)) && !flush;
  assign disp_acc   = bus.disp_vld && disp_rdy_w;
  assign wr_idx     = count_q - CW'(issue);

  // Entries at and above the issued slot take their upper neighbour; the
  // dispatch write slot is the top of the queue after that collapse.
  always_comb begin : p_load
    logic shifting;
    shifting = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      shifting     = shifting || (issue && sel_oh[i]);
      load_en[i]   = shifting;
      load_vld[i]  = shifting && vld[i+1];
      load_data[i] = ent[i+1];
      if (disp_acc && (CW'(i) == wr_idx)) begin
        load_en[i]   = 1'b1;
        load_vld[i]  = 1'b1;
        load_data[i] = disp_ent;
      end
    end
  end

  assign count_d = flush ? '0 : (count_q + CW'(disp_acc) - CW'(issue));

  always_ff @(posedge clk or posedge rst_clk) begin
    if (rst_clk) count_q <= '0;
    else         count_q <= count_d;
  end

  assign bus.disp_rdy                = disp_rdy_w;
  assign bus.iq_count                = count_q;
  assign bus.idu_exu_alu_vld         = issue;
  assign bus.idu_exu_alu_iid         = iss_ent.iid;
  assign bus.idu_exu_alu_opcode      = iss_ent.opcode;
  assign bus.idu_exu_alu_funct7      = iss_ent.funct7;
  assign bus.idu_exu_alu_funct3      = iss_ent.funct3;
  assign bus.idu_exu_alu_pc          = iss_ent.pc;
  assign bus.idu_exu_alu_psrc1_vld   = iss_ent.psrc1_vld;
  assign bus.idu_exu_alu_psrc1_value = iss_ent.psrc1_value;
  assign bus.idu_exu_alu_psrc2_vld   = iss_ent.psrc2_vld;
  assign bus.idu_exu_alu_psrc2_value = iss_ent.psrc2_value;
  assign bus.idu_exu_alu_pdst_vld    = iss_ent.pdst_vld;
  assign bus.idu_exu_alu_pdst        = iss_ent.pdst;
  assign bus.idu_exu_alu_imm_vld     = iss_ent.imm_vld;
  assign bus.idu_exu_alu_imm         = iss_ent.imm;

`ifdef IDU_ALU_IQ_DEBUG_PRINT_EN
  always @(negedge clk) begin
    if (!rst_clk && issue)
      $display("idu_alu_iq issue iid=%0d pc=%h src1=%h src2=%h",
               iss_ent.iid, iss_ent.pc, iss_ent.psrc1_value, iss_ent.psrc2_value);
    if (!rst_clk && disp_acc)
      $display("idu_alu_iq dispatch iid=%0d", bus.disp_iid);
  end
`else
  // simulation output disabled
`endif

endmodule

// File: tb/tb_idu_alu_iq.sv
// Directed plus randomized bench for idu_alu_iq against a queue-based reference model.
module tb_idu_alu_iq;
  import idu_alu_iq_pkg::*;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_clk;
  always #5 clk = ~clk;

  idu_alu_iq_if #(.DEPTH(DEPTH)) bus ();
  idu_alu_iq #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_clk(rst_clk), .bus(bus));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0]  iid;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [63:0] pc;
    logic        s1v, r1;
    logic [5:0]  p1;
    logic [63:0] v1;
    logic        s2v, r2;
    logic [5:0]  p2;
    logic [63:0] v2;
    logic        dv, iv;
    logic [5:0]  pd;
    logic [63:0] imm;
  } m_t;

  m_t q[$];
  logic [6:0] ops [6];
  logic [4:0] nid;

  function automatic logic [287:0] pk(m_t e);
    return {e.iid, e.op, e.f7, e.f3, e.pc, e.s1v, e.v1, e.s2v, e.v2, e.dv, e.pd, e.iv, e.imm};
  endfunction

  function automatic logic [287:0] obs();
    return {bus.idu_exu_alu_iid, bus.idu_exu_alu_opcode, bus.idu_exu_alu_funct7,
            bus.idu_exu_alu_funct3, bus.idu_exu_alu_pc, bus.idu_exu_alu_psrc1_vld,
            bus.idu_exu_alu_psrc1_value, bus.idu_exu_alu_psrc2_vld, bus.idu_exu_alu_psrc2_value,
            bus.idu_exu_alu_pdst_vld, bus.idu_exu_alu_pdst, bus.idu_exu_alu_imm_vld,
            bus.idu_exu_alu_imm};
  endfunction

  function automatic m_t wake(m_t e);
    if (bus.exu_idu_rf_alu_wb_vld) begin
      if (e.s1v && !e.r1 && e.p1 == bus.exu_idu_rf_alu_wb_preg) begin
        e.r1 = 1'b1; e.v1 = bus.exu_idu_rf_alu_wb_data;
      end
      if (e.s2v && !e.r2 && e.p2 == bus.exu_idu_rf_alu_wb_preg) begin
        e.r2 = 1'b1; e.v2 = bus.exu_idu_rf_alu_wb_data;
      end
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [287:0] o, input logic [287:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic idle();
    bus.rtu_global_flush = 1'b0;
    bus.disp_vld = 1'b0;
    bus.exu_idu_rf_alu_wb_vld = 1'b0;
    bus.exu_idu_rf_alu_wb_preg = '0;
    bus.exu_idu_rf_alu_wb_data = '0;
  endtask

  task automatic disp(input logic [4:0] iid,
                      input logic s1v, input logic [5:0] p1, input logic r1, input logic [63:0] v1,
                      input logic s2v, input logic [5:0] p2, input logic r2, input logic [63:0] v2);
    bus.disp_vld = 1'b1;
    bus.disp_iid = iid;
    bus.disp_opcode = ops[$urandom_range(0, 5)];
    bus.disp_funct7 = 7'($urandom);
    bus.disp_funct3 = 3'($urandom);
    bus.disp_pc = {$urandom, $urandom};
    bus.disp_psrc1_vld = s1v; bus.disp_psrc1 = p1; bus.disp_psrc1_rdy = r1; bus.disp_psrc1_value = v1;
    bus.disp_psrc2_vld = s2v; bus.disp_psrc2 = p2; bus.disp_psrc2_rdy = r2; bus.disp_psrc2_value = v2;
    bus.disp_pdst_vld = 1'($urandom);
    bus.disp_pdst = 6'($urandom);
    bus.disp_imm_vld = 1'($urandom);
    bus.disp_imm = {$urandom, $urandom};
  endtask

  task automatic wb(input logic v, input logic [5:0] p, input logic [63:0] d);
    bus.exu_idu_rf_alu_wb_vld = v;
    bus.exu_idu_rf_alu_wb_preg = p;
    bus.exu_idu_rf_alu_wb_data = d;
  endtask

  // Called one time unit after a rising edge with inputs already driven:
  // checks the cycle at posedge+4, then advances the model across the edge.
  task automatic tick();
    int   ei;
    logic acc;
    m_t   ne;
    #3;
    if (rst_clk) q.delete();
    ei = -1;
    if (!bus.rtu_global_flush)
      for (int i = 0; i < q.size(); i++)
        if (q[i].r1 && q[i].r2) begin ei = i; break; end
    chk("ctl", {bus.idu_exu_alu_vld, bus.iq_count, bus.disp_rdy},
        {ei >= 0, 4'(q.size()), !bus.rtu_global_flush && q.size() < DEPTH});
    chk("bundle", obs(), (ei >= 0) ? pk(q[ei]) : '0);
    @(posedge clk);
    if (rst_clk || bus.rtu_global_flush) q.delete();
    else begin
      acc = bus.disp_vld && q.size() < DEPTH;
      ne.iid = bus.disp_iid; ne.op = bus.disp_opcode; ne.f7 = bus.disp_funct7;
      ne.f3 = bus.disp_funct3; ne.pc = bus.disp_pc;
      ne.s1v = bus.disp_psrc1_vld; ne.p1 = bus.disp_psrc1;
      ne.r1 = !ne.s1v || bus.disp_psrc1_rdy;
      ne.v1 = (ne.s1v && bus.disp_psrc1_rdy) ? bus.disp_psrc1_value : 64'd0;
      ne.s2v = bus.disp_psrc2_vld; ne.p2 = bus.disp_psrc2;
      ne.r2 = !ne.s2v || bus.disp_psrc2_rdy;
      ne.v2 = (ne.s2v && bus.disp_psrc2_rdy) ? bus.disp_psrc2_value : 64'd0;
      ne.dv = bus.disp_pdst_vld; ne.pd = bus.disp_pdst;
      ne.iv = bus.disp_imm_vld; ne.imm = bus.disp_imm;
      for (int i = 0; i < q.size(); i++) q[i] = wake(q[i]);
      ne = wake(ne);
      if (ei >= 0) q.delete(ei);
      if (acc) q.push_back(ne);
    end
    #1;
  endtask

  initial begin
    ops = '{R_ALU64, R_ALU32, I_ALU64, I_ALU32, U_AUIPC, U_LUI};
    rst_clk = 1'b1;
    idle();
    disp(5'd0, 1'b0, 6'd0, 1'b0, 64'd0, 1'b0, 6'd0, 1'b0, 64'd0);
    bus.disp_vld = 1'b0;
    #1;
    chk("reset_out", {obs(), bus.idu_exu_alu_vld, bus.iq_count, bus.disp_rdy}, {288'd0, 1'b0, 4'd0, 1'b1});
    @(posedge clk); @(posedge clk); #1;
    rst_clk = 1'b0;

    // single fully-ready instruction
    disp(5'd3, 1'b1, 6'd1, 1'b1, 64'd5, 1'b1, 6'd2, 1'b1, 64'd7);
    tick();
    bus.disp_vld = 1'b0;
    chk("t1_issue", {bus.idu_exu_alu_vld, bus.idu_exu_alu_iid, bus.idu_exu_alu_psrc1_value,
        bus.idu_exu_alu_psrc2_value}, {1'b1, 5'd3, 64'd5, 64'd7});
    tick();
    chk("t1_drain", {bus.idu_exu_alu_vld, bus.iq_count}, {1'b0, 4'd0});

    // younger ready instruction overtakes an older waiting one
    disp(5'd1, 1'b1, 6'd12, 1'b0, 64'd0, 1'b0, 6'd0, 1'b0, 64'd0);
    tick();
    disp(5'd2, 1'b1, 6'd1, 1'b1, 64'd11, 1'b1, 6'd2, 1'b1, 64'd22);
    tick();
    bus.disp_vld = 1'b0;
    chk("t2_first", {bus.idu_exu_alu_vld, bus.idu_exu_alu_iid}, {1'b1, 5'd2});
    wb(1'b1, 6'd12, 64'hABCD);
    tick();
    wb(1'b0, 6'd0, 64'd0);
    chk("t2_wake", {bus.idu_exu_alu_vld, bus.idu_exu_alu_iid, bus.idu_exu_alu_psrc1_value},
        {1'b1, 5'd1, 64'hABCD});
    tick();

    // wakeup in the dispatch cycle
    disp(5'd4, 1'b1, 6'd3, 1'b1, 64'd9, 1'b1, 6'd9, 1'b0, 64'd0);
    wb(1'b1, 6'd9, 64'h55);
    tick();
    idle();
    chk("t3_dispwake", {bus.idu_exu_alu_vld, bus.idu_exu_alu_iid, bus.idu_exu_alu_psrc2_value},
        {1'b1, 5'd4, 64'h55});
    tick();

    // fill the queue with waiting entries, then wake the middle one
    for (int i = 0; i < DEPTH; i++) begin
      disp(5'(10 + i), 1'b1, 6'(16 + i), 1'b0, 64'd0, 1'b0, 6'd0, 1'b0, 64'd0);
      tick();
    end
    chk("t4_full", {bus.disp_rdy, bus.iq_count, bus.idu_exu_alu_vld}, {1'b0, 4'd8, 1'b0});
    wb(1'b1, 6'd20, 64'h1234);
    tick();
    wb(1'b0, 6'd0, 64'd0);
    chk("t4_issue4", {bus.idu_exu_alu_vld, bus.idu_exu_alu_iid, bus.disp_rdy, bus.iq_count},
        {1'b1, 5'd14, 1'b0, 4'd8});
    tick();
    bus.disp_vld = 1'b0;
    chk("t4_after", {bus.disp_rdy, bus.iq_count, bus.idu_exu_alu_vld}, {1'b1, 4'd7, 1'b0});
    wb(1'b1, 6'd22, 64'h77);
    tick();
    wb(1'b0, 6'd0, 64'd0);
    chk("t4_shifted", {bus.idu_exu_alu_iid, bus.idu_exu_alu_psrc1_value}, {5'd16, 64'h77});
    tick();
    bus.rtu_global_flush = 1'b1;
    tick();
    idle();

    // flush dominates a ready queue and a simultaneous dispatch
    for (int i = 0; i < 5; i++) begin
      disp(5'(20 + i), 1'b1, 6'd30, 1'b0, 64'd0, 1'b0, 6'd0, 1'b0, 64'd0);
      tick();
    end
    bus.disp_vld = 1'b0;
    wb(1'b1, 6'd30, 64'h3030);
    tick();
    wb(1'b0, 6'd0, 64'd0);
    disp(5'd25, 1'b0, 6'd0, 1'b0, 64'd0, 1'b0, 6'd0, 1'b0, 64'd0);
    bus.rtu_global_flush = 1'b1;
    #1;
    chk("t5_flush_comb", {bus.idu_exu_alu_vld, bus.disp_rdy, bus.iq_count}, {1'b0, 1'b0, 4'd5});
    tick();
    idle();
    chk("t5_flushed", {bus.idu_exu_alu_vld, bus.iq_count}, {1'b0, 4'd0});
    tick();

    // reset during back-to-back issue
    for (int i = 0; i < 3; i++) begin
      disp(5'(26 + i), 1'b1, 6'd31, 1'b0, 64'd0, 1'b0, 6'd0, 1'b0, 64'd0);
      tick();
    end
    bus.disp_vld = 1'b0;
    wb(1'b1, 6'd31, 64'h31);
    tick();
    wb(1'b0, 6'd0, 64'd0);
    tick();
    rst_clk = 1'b1;
    #1;
    chk("t6_rst_out", {obs(), bus.idu_exu_alu_vld, bus.iq_count}, {288'd0, 1'b0, 4'd0});
    tick();
    rst_clk = 1'b0;
    chk("t6_rdy", {bus.disp_rdy, bus.iq_count}, {1'b1, 4'd0});
    tick();

    // randomized traffic against the model
    nid = 5'd0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) != 0)
        disp(nid, 1'($urandom), 6'($urandom_range(0, 7)), 1'($urandom), {$urandom, $urandom},
             1'($urandom), 6'($urandom_range(0, 7)), 1'($urandom), {$urandom, $urandom});
      else
        bus.disp_vld = 1'b0;
      if (bus.disp_vld) nid = nid + 5'd1;
      wb(1'($urandom), 6'($urandom_range(0, 7)), {$urandom, $urandom});
      bus.rtu_global_flush = ($urandom_range(0, 39) == 0);
      tick();
    end
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/idu_alu_iq.md
# idu_alu_iq

Single-issue, data-capture issue queue in the IDU that holds renamed ALU instructions until their source operands are available, then issues the oldest ready one per cycle on the `idu_exu_alu_*` interface to the EXU ALU. It snoops the ALU writeback bus (`exu_idu_rf_alu_wb_*`) to wake up waiting entries and capture operand data. It is the issuing end of the IDU→EXU ALU protocol.

## Interface

**Parameters**
- `DEPTH`, default 8: number of queue entries (2..16).

**Ports**
- `clk` in 1: clock, rising edge.
- `rst_clk` in 1: asynchronous reset, active-high.
- `rtu_global_flush` in 1: discard all entries.
- `disp_vld` in 1: dispatch request.
- `disp_rdy` out 1: queue can accept a dispatch.
- `disp_iid` in 5, `disp_opcode` in 7, `disp_funct7` in 7, `disp_funct3` in 3, `disp_pc` in 64: instruction fields.
- `disp_psrcN_vld` in 1: source N is used (N = 1, 2).
- `disp_psrcN` in 6: source N physical register.
- `disp_psrcN_rdy` in 1: source N value is valid at dispatch.
- `disp_psrcN_value` in 64: source N value, meaningful only when rdy.
- `disp_pdst_vld` in 1, `disp_pdst` in 6, `disp_imm_vld` in 1, `disp_imm` in 64: destination and immediate.
- `exu_idu_rf_alu_wb_vld` in 1, `exu_idu_rf_alu_wb_preg` in 6, `exu_idu_rf_alu_wb_data` in 64: writeback snoop.
- `idu_exu_alu_vld` out 1, plus `idu_exu_alu_iid`, `_opcode`, `_funct7`, `_funct3`, `_pc`, `_psrc1_vld`, `_psrc1_value`, `_psrc2_vld`, `_psrc2_value`, `_pdst_vld`, `_pdst`, `_imm_vld`, `_imm` out (widths as the matching `disp_*` fields): issue bundle.
- `iq_count` out $clog2(DEPTH+1): occupied entries.

## Operation

- Collapsing queue: entry 0 is the oldest. A new entry is written at index `count - (issue ? 1 : 0)`. On issue, entries above the issued index shift down by one.
- Entry state: valid, all dispatch fields, and per source a `rdy` bit plus a 64-bit captured value. A source with `psrcN_vld = 0` is ready at dispatch, with value 0.
- Wakeup: when `exu_idu_rf_alu_wb_vld` is high, every valid entry with `psrcN_vld & ~rdy & psrcN == wb_preg` sets `rdy` and captures `wb_data`.
- Dispatch-cycle wakeup: if a dispatching source is not ready and matches the writeback in the same cycle, it is written as ready with `wb_data`.
- Select: the lowest-index valid entry with both sources ready. `idu_exu_alu_vld = 1` whenever such an entry exists and there is no flush. All bundle fields are driven combinationally from that entry, with `psrcN_value` taken from the captured value. The bundle is all-zero when not valid.
- No backpressure from the EXU: every cycle with `idu_exu_alu_vld` high is an issue, and that entry is removed at the next edge.
- `disp_rdy = (count < DEPTH)`. Space freed by an issue in the same cycle is not counted.
- Flush: `rtu_global_flush` forces `idu_exu_alu_vld = 0` and `disp_rdy = 0` combinationally. At the next edge all valid bits clear and count becomes 0. Flush dominates dispatch, issue and wakeup.
- Reset: all entries invalid and `count = 0`. As a result every output is 0, except `disp_rdy = 1`.

## Timing

- Dispatch accepted at edge N. Earliest issue is cycle N+1, if both sources were ready at dispatch.
- Writeback visible in cycle X. The woken entry is issue-eligible from cycle X+1.
- Dependent chain: producer issued in cycle N, its writeback in N+1, consumer issued in N+2.
- Dispatch and issue in the same cycle leave the count unchanged.
- Full queue: `disp_rdy` stays low even while an issue is in progress.
- Reset asserted mid-operation clears the queue asynchronously. No issue occurs while reset is high.

## Configuration

- `IDU_ALU_IQ_DEBUG_PRINT_EN`: when defined, a `$display` on the negative clock edge prints the iid, pc and both operand values for each issue, and the iid for each dispatch.
- When undefined, no simulation output is produced. Synthesized logic is identical either way.

## Structure

- Shared package/header holds:
  - opcode constants (`R_ALU64`, `R_ALU32`, `I_ALU64`, `I_ALU32`, `U_AUIPC`, `U_LUI`);
  - width constants `IID_W = 5`, `PREG_W = 6`, `XLEN = 64`;
  - a packed entry typedef.
- One sub-module, `idu_alu_iq_entry`: a single entry's storage, the wakeup comparators and value capture, and the ready output. The top level contains the select, shift and count logic.

## Test plan

- Reset, then dispatch `iid = 3`, both sources ready, `psrc1_value = 5`, `psrc2_value = 7` → cycle +1: `idu_exu_alu_vld = 1`, `iid = 3`, values 5 and 7. Cycle +2: vld = 0, count = 0.
- Dispatch `iid = 1` with `psrc1 = 12` not ready, then `iid = 2` fully ready → `iid = 2` issues first. Writeback `preg = 12`, `data = 0xABCD` → next cycle `iid = 1` issues with `psrc1_value = 0xABCD`.
- Dispatch with `psrc2 = 9` not ready, with writeback `preg = 9`, `data = 0x55` in the same cycle → issues at +1 with `psrc2_value = 0x55`.
- Fill 8 entries, none ready → `disp_rdy = 0`, `iq_count = 8`. Wake entry 4 → it issues, the entries above it shift down, and `disp_rdy = 1` the cycle after.
- Queue holds 5 ready entries and a flush is asserted together with a dispatch → `idu_exu_alu_vld = 0` that cycle, then count = 0 and no issue afterwards.
- Reset asserted during back-to-back issue → outputs zero immediately, and `disp_rdy = 1` after reset is released.
